// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM states,
// recoded digit format and the extended-multiplier width calculation.
package booth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // zero overrides the other fields; x2 selects 2*M, neg selects subtraction
    typedef struct packed {
        logic neg;
        logic x2;
        logic zero;
    } booth_digit_t;

    // Multiplier padded by at least one extension bit, rounded up to whole digits
    function automatic int unsigned qw_calc(input int unsigned mplr_w);
        return 2 * ((mplr_w + 2) / 2);
    endfunction

endpackage

// File: rtl/booth4_mult_seq_if.sv
// Start/done handshake and operand/result bus of the sequential Booth multiplier.
// master drives the request; slave is the multiplier.
interface booth4_mult_seq_if #(
    parameter int unsigned MCAND_W = 8,
    parameter int unsigned MPLR_W  = 4
) ();

    logic                       start;
    logic                       signed_mode;
    logic [MCAND_W-1:0]         multiplicand;
    logic [MPLR_W-1:0]          multiplier;
    logic                       busy;
    logic                       done;
    logic [MCAND_W+MPLR_W-1:0]  product;

    modport master (
        output start,
        output signed_mode,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  signed_mode,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );

endinterface

// File: rtl/booth4_recoder.sv
// Radix-4 Booth recoder: overlapped triplet {q1, q0, q_prev} to a signed digit
// in {-2, -1, 0, +1, +2}.
module booth4_recoder
    import booth_pkg::*;
(
    input  logic [2:0]   triplet_i,
    output booth_digit_t digit_o
);

    always_comb begin
        digit_o = '{neg: 1'b0, x2: 1'b0, zero: 1'b1};
        unique case (triplet_i)
            3'b000, 3'b111: digit_o = '{neg: 1'b0, x2: 1'b0, zero: 1'b1};
            3'b001, 3'b010: digit_o = '{neg: 1'b0, x2: 1'b0, zero: 1'b0};
            3'b011:         digit_o = '{neg: 1'b0, x2: 1'b1, zero: 1'b0};
            3'b100:         digit_o = '{neg: 1'b1, x2: 1'b1, zero: 1'b0};
            3'b101, 3'b110: digit_o = '{neg: 1'b1, x2: 1'b0, zero: 1'b0};
        endcase
    end

endmodule

// File: rtl/booth4_mult_seq.sv
// Sequential radix-4 Booth multiplier retiring one digit per clock, with a
// start/done handshake, signed/unsigned mode and a held product register.
module booth4_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned MCAND_W = 8,
    parameter int unsigned MPLR_W  = 4
) (
    input logic              clk,
    input logic              rst,
    booth4_mult_seq_if.slave bus
);

    localparam int unsigned QW   = qw_calc(MPLR_W);
    localparam int unsigned NDIG = QW / 2;
    localparam int unsigned P_W  = MCAND_W + MPLR_W;
    localparam int unsigned AW   = MCAND_W + 2;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    state_e state_q, state_d;

    logic [AW-1:0]  m_q, m_d;
    logic [AW-1:0]  a_q, a_d;
    logic [QW-1:0]  q_q, q_d;
    logic           q_prev_q, q_prev_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [P_W-1:0] prod_q, prod_d;

    logic          load;
    logic          run_last;
    booth_digit_t  digit;
    logic [AW-1:0] m_sel;
    logic [AW-1:0] addend;
    logic [AW-1:0] a_sum;
    logic [AW-1:0] a_sh;
    logic [QW-1:0] q_sh;
    logic          ext_m;
    logic          ext_q;

    // A new request is only taken when no multiply is in flight
    assign load     = (state_q != StRun) && bus.start;
    assign run_last = (state_q == StRun) && (cnt_q == CW'(NDIG - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (run_last) state_d = StDone;
            StDone:  state_d = bus.start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q == StRun);
        bus.done    = (state_q == StDone);
        bus.product = prod_q;
    end

    // ---------------- Datapath ----------------
    booth4_recoder u_recoder (
        .triplet_i ({q_q[1:0], q_prev_q}),
        .digit_o   (digit)
    );

    always_comb begin
        m_sel = digit.x2 ? {m_q[AW-2:0], 1'b0} : m_q;
        if (digit.zero) begin
            addend = '0;
        end else if (digit.neg) begin
            addend = ~m_sel + AW'(1);
        end else begin
            addend = m_sel;
        end
        a_sum = a_q + addend;
        // Arithmetic shift of {A, Q, q_prev} right by one digit
        a_sh  = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
        q_sh  = {a_sum[1:0], q_q[QW-1:2]};
    end

    assign ext_m = bus.signed_mode & bus.multiplicand[MCAND_W-1];
    assign ext_q = bus.signed_mode & bus.multiplier[MPLR_W-1];

    always_comb begin
        m_d      = m_q;
        a_d      = a_q;
        q_d      = q_q;
        q_prev_d = q_prev_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        if (load) begin
            m_d      = {{2{ext_m}}, bus.multiplicand};
            q_d      = {{(QW - MPLR_W){ext_q}}, bus.multiplier};
            a_d      = '0;
            q_prev_d = 1'b0;
            cnt_d    = '0;
        end else if (state_q == StRun) begin
            a_d      = a_sh;
            q_d      = q_sh;
            q_prev_d = q_q[1];
            cnt_d    = cnt_q + CW'(1);
        end
        // Upper bits of {A, Q} are pure extension of the P_W-bit result
        if (run_last) begin
            prod_d = P_W'({a_sh, q_sh});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q      <= '0;
            a_q      <= '0;
            q_q      <= '0;
            q_prev_q <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            m_q      <= m_d;
            a_q      <= a_d;
            q_q      <= q_d;
            q_prev_q <= q_prev_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: tb/tb_booth4_mult_seq.sv
// Self-checking bench for booth4_mult_seq: cycle model for the default 8x4 instance,
// transaction checks for 16x16 and 8x5 instances.
module tb_booth4_mult_seq;

    localparam int NDIG0 = 3;   // 8x4: QW = 6
    localparam int NDIG1 = 9;   // 16x16: QW = 18
    localparam int NDIG2 = 3;   // 8x5: QW = 6

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth4_mult_seq_if #(.MCAND_W(8),  .MPLR_W(4))  bus0 ();
    booth4_mult_seq_if #(.MCAND_W(16), .MPLR_W(16)) bus1 ();
    booth4_mult_seq_if #(.MCAND_W(8),  .MPLR_W(5))  bus2 ();

    booth4_mult_seq #(.MCAND_W(8),  .MPLR_W(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
    booth4_mult_seq #(.MCAND_W(16), .MPLR_W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    booth4_mult_seq #(.MCAND_W(8),  .MPLR_W(5))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic product, truncated to aw+bw bits
    function automatic logic [63:0] ref_mul(input bit sm, input logic [63:0] a, input int aw,
                                            input logic [63:0] b, input int bw);
        longint sa, sb, p;
        logic [63:0] mask;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[aw-1]) sa = sa - (longint'(1) << aw);
        if (sm && b[bw-1]) sb = sb - (longint'(1) << bw);
        p    = sa * sb;
        mask = (64'd1 << (aw + bw)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    // Cycle model of dut0: m_cyc counts cycles since an accepted request
    int          m_cyc  = 0;
    logic [11:0] m_pend = '0;
    logic [11:0] m_prod = '0;
    bit          m_en   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc  <= 0;
            m_prod <= '0;
        end else if ((m_cyc == 0 || m_cyc == NDIG0 + 1) && bus0.start) begin
            m_cyc  <= 1;
            m_pend <= 12'(ref_mul(bus0.signed_mode, 64'(bus0.multiplicand), 8,
                                  64'(bus0.multiplier), 4));
        end else if (m_cyc == NDIG0 + 1) begin
            m_cyc <= 0;
        end else if (m_cyc > 0) begin
            m_cyc <= m_cyc + 1;
            if (m_cyc == NDIG0) m_prod <= m_pend;
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            check("busy",    64'(bus0.busy),    64'(m_cyc >= 1 && m_cyc <= NDIG0));
            check("done",    64'(bus0.done),    64'(m_cyc == NDIG0 + 1));
            check("product", 64'(bus0.product), 64'(m_prod));
        end
    end

    // Issue one request and return cycles from the start edge to done visible
    task automatic run0(input bit sm, input logic [7:0] a, input logic [3:0] b, output int lat);
        bus0.start = 1'b1; bus0.signed_mode = sm; bus0.multiplicand = a; bus0.multiplier = b;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        lat = 1;
        while (!bus0.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run1(input bit sm, input logic [15:0] a, input logic [15:0] b);
        int lat;
        bus1.start = 1'b1; bus1.signed_mode = sm; bus1.multiplicand = a; bus1.multiplier = b;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        lat = 1;
        while (!bus1.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w16_lat", 64'(lat), 64'(NDIG1 + 1));
        check("w16_prod", 64'(bus1.product), ref_mul(sm, 64'(a), 16, 64'(b), 16));
    endtask

    task automatic run2(input bit sm, input logic [7:0] a, input logic [4:0] b);
        int lat;
        bus2.start = 1'b1; bus2.signed_mode = sm; bus2.multiplicand = a; bus2.multiplier = b;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        lat = 1;
        while (!bus2.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w5_lat", 64'(lat), 64'(NDIG2 + 1));
        check("w5_prod", 64'(bus2.product), ref_mul(sm, 64'(a), 8, 64'(b), 5));
    endtask

    initial begin
        int lat;
        logic [7:0]  ca [5];
        logic [3:0]  cb [5];
        logic [15:0] cw [5];
        logic [4:0]  c5 [5];
        ca = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        cb = '{4'h0, 4'h1, 4'h7, 4'h8, 4'hF};
        cw = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        c5 = '{5'h00, 5'h01, 5'h0F, 5'h10, 5'h1F};

        rst = 1'b1;
        bus0.start = 1'b0; bus0.signed_mode = 1'b0; bus0.multiplicand = '0; bus0.multiplier = '0;
        bus1.start = 1'b0; bus1.signed_mode = 1'b0; bus1.multiplicand = '0; bus1.multiplier = '0;
        bus2.start = 1'b0; bus2.signed_mode = 1'b0; bus2.multiplicand = '0; bus2.multiplier = '0;
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        m_en = 1'b1;
        check("rst_busy", 64'(bus0.busy), 64'd0);
        check("rst_done", 64'(bus0.done), 64'd0);
        check("rst_prod", 64'(bus0.product), 64'd0);
        @(posedge clk); #1;

        // Unsigned 200 x 15
        run0(1'b0, 8'hC8, 4'hF, lat);
        check("t1_lat", 64'(lat), 64'd4);
        check("t1_prod", 64'(bus0.product), 64'hBB8);
        @(posedge clk); #1;

        // Signed and unsigned edge operands
        run0(1'b1, 8'h80, 4'h8, lat);
        check("t2_neg_neg", 64'(bus0.product), 64'h400);
        run0(1'b1, 8'hFF, 4'h7, lat);
        check("t2_m1x7", 64'(bus0.product), 64'hFF9);
        check("t2_b2b_lat", 64'(lat), 64'd4);
        run0(1'b0, 8'hFF, 4'h7, lat);
        check("t2_u255x7", 64'(bus0.product), 64'h6F9);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // start held through RUN with changing operands, then held in the DONE cycle
        bus0.start = 1'b1; bus0.signed_mode = 1'b0; bus0.multiplicand = 8'h12; bus0.multiplier = 4'h3;
        @(posedge clk); #1;
        lat = 1;
        while (!bus0.done && lat < 40) begin
            bus0.multiplicand = 8'($urandom);
            bus0.multiplier   = 4'($urandom);
            bus0.signed_mode  = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("t3_ignore_lat", 64'(lat), 64'd4);
        check("t3_ignore_prod", 64'(bus0.product), 64'h036);
        bus0.signed_mode = 1'b0; bus0.multiplicand = 8'h05; bus0.multiplier = 4'h6;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        lat = 1;
        while (!bus0.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t3_done_start_lat", 64'(lat), 64'd4);
        check("t3_done_start_prod", 64'(bus0.product), 64'h01E);
        @(posedge clk); #1;

        // Reset in the second RUN cycle
        bus0.start = 1'b1; bus0.signed_mode = 1'b0; bus0.multiplicand = 8'hAB; bus0.multiplier = 4'hC;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_busy", 64'(bus0.busy), 64'd0);
        check("t4_done", 64'(bus0.done), 64'd0);
        check("t4_prod", 64'(bus0.product), 64'd0);
        run0(1'b0, 8'h03, 4'h5, lat);
        check("t4_3x5", 64'(bus0.product), 64'h00F);
        @(posedge clk); #1;

        // Corner sweep on every width, both modes
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    run0(1'(s), ca[i], cb[j], lat);
                    check("c0_prod", 64'(bus0.product), ref_mul(1'(s), 64'(ca[i]), 8, 64'(cb[j]), 4));
                    check("c0_lat", 64'(lat), 64'(NDIG0 + 1));
                    run1(1'(s), cw[i], cw[j]);
                    run2(1'(s), ca[i], c5[j]);
                    if (((i + j) % 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
            end
        end

        // Random operands
        for (int k = 0; k < 200; k++) begin
            run0(1'($urandom), 8'($urandom), 4'($urandom), lat);
            if (($urandom % 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        for (int k = 0; k < 1000; k++) begin
            run1(1'(k % 2), 16'($urandom), 16'($urandom));
        end
        for (int k = 0; k < 1000; k++) begin
            run2(1'(k % 2), 8'($urandom), 5'($urandom));
        end

        @(posedge clk); #1;
        m_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
